exec_pipe: RTL and testbench

Parametrised execute stage between decode/register-read and writeback. Adds a valid/ready handshake, a registered result, a flush input, and branch/jump resolution with a one-cycle redirect pulse. Single-cycle ALU ops complete in 1 cycle. MUL/DIVU/REMU run on an iterative unit that takes XLEN cycles, so the stage stalls upstream while they run.

---
 rtl/exec_pkg.sv | 30 +++
 rtl/iter_muldiv.sv | 88 ++++++++
 rtl/exec_pipe.sv | 156 +++++++++++++++
 tb/tb_exec_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: operation encoding, FSM states and
// small classification helpers used by the stage and its iterative unit.
package exec_pkg;

  typedef enum logic [4:0] {
    ADD, SUB, AND, OR, XOR,
    SLL, SRL, SRA,
    SLT, SLTU,
    MUL, DIVU, REMU,
    JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU
  } exec_op_t;

  typedef enum logic {
    IDLE,
    BUSY
  } exec_state_t;

  // Ops served by the multi-cycle multiply/divide unit.
  function automatic logic is_muldiv(input exec_op_t op);
    return (op == MUL) || (op == DIVU) || (op == REMU);
  endfunction

  // Conditional branches never write a destination register.
  function automatic logic is_branch(input exec_op_t op);
    return (op == BEQ) || (op == BNE) || (op == BLT) ||
           (op == BGE) || (op == BLTU) || (op == BGEU);
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply (shift-add) and unsigned divide (restoring) unit.
// Operands are latched on start; the last of the XLEN iterations is
// evaluated combinationally so the result is presented in the XLEN-th
// cycle after start and held there until abort or a new start.
module iter_muldiv
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  exec_op_t        op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  // acc: product accumulator or partial remainder.
  // opa: shifting multiplicand or dividend/quotient register.
  // opb: shifting multiplier or fixed divisor.
  logic [XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0] opa_reg, opa_next;
  logic [XLEN-1:0] opb_reg, opb_next;
  logic [CW-1:0]   cnt_reg;
  logic            run_reg, mul_reg, rem_reg;
  logic [XLEN:0]   rem_shift, diff;

  // One iteration of either algorithm; a zero divisor naturally yields an
  // all-ones quotient and the dividend as remainder.
  always_comb begin
    rem_shift = {acc_reg, opa_reg[XLEN-1]};
    diff      = rem_shift - {1'b0, opb_reg};
    acc_next  = acc_reg;
    opa_next  = opa_reg;
    opb_next  = opb_reg;
    if (mul_reg) begin
      acc_next = acc_reg + (opb_reg[0] ? opa_reg : '0);
      opa_next = opa_reg << 1;
      opb_next = opb_reg >> 1;
    end else if (!diff[XLEN]) begin
      acc_next = diff[XLEN-1:0];
      opa_next = {opa_reg[XLEN-2:0], 1'b1};
    end else begin
      acc_next = rem_shift[XLEN-1:0];
      opa_next = {opa_reg[XLEN-2:0], 1'b0};
    end
  end

  assign done   = run_reg && (cnt_reg == LAST);
  assign busy   = run_reg && (cnt_reg != LAST);
  assign result = (mul_reg || rem_reg) ? acc_next : opa_next;

  // Operand latch on start, then step until the final iteration is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg <= 1'b0;
      cnt_reg <= '0;
      acc_reg <= '0;
      opa_reg <= '0;
      opb_reg <= '0;
      mul_reg <= 1'b0;
      rem_reg <= 1'b0;
    end else if (abort) begin
      run_reg <= 1'b0;
    end else if (start) begin
      run_reg <= 1'b1;
      cnt_reg <= '0;
      acc_reg <= '0;
      opa_reg <= a;
      opb_reg <= b;
      mul_reg <= (op == MUL);
      rem_reg <= (op == REMU);
    end else if (run_reg && (cnt_reg != LAST)) begin
      acc_reg <= acc_next;
      opa_reg <= opa_next;
      opb_reg <= opb_next;
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/exec_pipe.sv
// Execute stage: single-cycle ALU and branch/jump resolution, with
// multiply/divide offloaded to an iterative unit while upstream stalls.
module exec_pipe
  import exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_STEP   = 1,
  parameter int MD_ENABLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  exec_op_t        in_op,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int   SHW   = $clog2(XLEN);
  localparam logic MD_ON = (MD_ENABLE != 0);

  exec_state_t     state_reg;
  logic            out_valid_reg, redirect_valid_reg;
  logic [XLEN-1:0] out_result_reg, redirect_pc_reg;
  logic [4:0]      out_rd_reg, rd_hold_reg;

  logic            accept, can_load, md_start, md_load, md_abort;
  logic            md_busy, md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] alu_res, target;
  logic            take;
  logic [SHW-1:0]  shamt;
  logic [4:0]      wb_rd;

  assign can_load = !out_valid_reg || out_ready;
  assign in_ready = (state_reg == IDLE) && can_load;
  assign accept   = in_valid && in_ready && !flush;
  assign md_start = accept && MD_ON && is_muldiv(in_op);
  assign md_load  = (state_reg == BUSY) && md_done && !md_busy && can_load;
  assign md_abort = flush || md_load;
  assign shamt    = in_rs2[SHW-1:0];
  assign wb_rd    = is_branch(in_op) ? 5'd0 : in_rd;

  // Single-cycle result plus redirect decision for the offered instruction.
  always_comb begin
    alu_res = '0;
    take    = 1'b0;
    target  = in_pc + in_imm;
    case (in_op)
      ADD:  alu_res = in_rs1 + in_rs2;
      SUB:  alu_res = in_rs1 - in_rs2;
      AND:  alu_res = in_rs1 & in_rs2;
      OR:   alu_res = in_rs1 | in_rs2;
      XOR:  alu_res = in_rs1 ^ in_rs2;
      SLL:  alu_res = in_rs1 << shamt;
      SRL:  alu_res = in_rs1 >> shamt;
      SRA:  alu_res = $unsigned($signed(in_rs1) >>> shamt);
      SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(in_rs2))};
      SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_rs1 < in_rs2)};
      JAL: begin
        alu_res = in_pc + XLEN'(PC_STEP);
        take    = 1'b1;
      end
      JALR: begin
        alu_res = in_pc + XLEN'(PC_STEP);
        target  = in_rs1 + in_imm;
        take    = 1'b1;
      end
      BEQ:  take = (in_rs1 == in_rs2);
      BNE:  take = (in_rs1 != in_rs2);
      BLT:  take = ($signed(in_rs1) < $signed(in_rs2));
      BGE:  take = ($signed(in_rs1) >= $signed(in_rs2));
      BLTU: take = (in_rs1 < in_rs2);
      BGEU: take = (in_rs1 >= in_rs2);
      default: alu_res = '0;  // MUL/DIVU/REMU when the unit is disabled
    endcase
  end

  iter_muldiv #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (in_op),
    .a     (in_rs1),
    .b     (in_rs2),
    .abort (md_abort),
    .busy  (md_busy),
    .done  (md_done),
    .result(md_result)
  );

  // Stage FSM and output register; flush wins over accept and completion,
  // and the redirect pulse is only raised on the cycle a result is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      out_valid_reg      <= 1'b0;
      out_result_reg     <= '0;
      out_rd_reg         <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      rd_hold_reg        <= '0;
    end else if (flush) begin
      state_reg          <= IDLE;
      out_valid_reg      <= 1'b0;
      redirect_valid_reg <= 1'b0;
    end else begin
      redirect_valid_reg <= 1'b0;
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (md_start) begin
              state_reg   <= BUSY;
              rd_hold_reg <= in_rd;
            end else begin
              out_valid_reg      <= 1'b1;
              out_result_reg     <= alu_res;
              out_rd_reg         <= wb_rd;
              redirect_valid_reg <= take;
              if (take) redirect_pc_reg <= target;
            end
          end
        end
        BUSY: begin
          if (md_load) begin
            state_reg      <= IDLE;
            out_valid_reg  <= 1'b1;
            out_result_reg <= md_result;
            out_rd_reg     <= rd_hold_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_result     = out_result_reg;
  assign out_rd         = out_rd_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_exec_pipe.sv
// Directed bench for exec_pipe: expected results are queued when an
// instruction is offered and compared when the stage presents it.
module tb_exec_pipe;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, redirect_valid;
  exec_op_t    in_op;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2, out_result, redirect_pc;
  logic [4:0]  in_rd, out_rd;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        redir;
    logic [31:0] pc;
    logic        chk_res;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  exec_pipe #(.XLEN(32), .PC_STEP(1), .MD_ENABLE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input exec_op_t op, input logic [31:0] pc, imm, rs1, rs2,
                       input logic [4:0] rd, input logic [31:0] eres, input logic [4:0] erd,
                       input logic eredir, input logic [31:0] epc, input logic chk);
    exp_t e;
    check("in_ready before issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    e.res = eres; e.rd = erd; e.redir = eredir; e.pc = epc; e.chk_res = chk;
    sb.push_back(e);
    $display("issue %s pc=%h imm=%h rs1=%h rs2=%h rd=%0d", op.name(), pc, imm, rs1, rs2, rd);
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input int lat, input string tag);
    int   n;
    exp_t e;
    n = 1;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " pending"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " out_rd"}, {27'd0, out_rd}, {27'd0, e.rd});
      check({tag, " redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e.redir});
      if (e.chk_res) check({tag, " out_result"}, out_result, e.res);
      if (e.redir)   check({tag, " redirect_pc"}, redirect_pc, e.pc);
      $display("result %s lat=%0d res=%h rd=%0d redir=%b pc=%h", tag, n, out_result, out_rd,
               redirect_valid, redirect_pc);
    end
  endtask

  task automatic watch_quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (out_valid || redirect_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = ADD; out_ready = 1'b1;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    #2;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_rd", {27'd0, out_rd}, 32'd0);
    check("reset redirect_pc", redirect_pc, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    rst = 1'b0;
    step();

    // Back-to-back single-cycle ALU ops
    issue(ADD, 0, 0, 32'hFFFF_FFFF, 32'h1, 5, 32'h0, 5, 0, 0, 1);
    expect_out(1, "add");
    check("add in_ready", {31'd0, in_ready}, 32'd1);
    issue(SUB, 0, 0, 32'd5, 32'd7, 3, 32'hFFFF_FFFE, 3, 0, 0, 1);
    expect_out(1, "sub");
    issue(AND, 0, 0, 32'hF0F0_FF00, 32'h0FF0_0FF0, 4, 32'h00F0_0F00, 4, 0, 0, 1);
    expect_out(1, "and");
    issue(OR, 0, 0, 32'hF0F0_FF00, 32'h0FF0_0FF0, 4, 32'hFFF0_FFF0, 4, 0, 0, 1);
    expect_out(1, "or");
    issue(XOR, 0, 0, 32'hF0F0_FF00, 32'h0FF0_0FF0, 4, 32'hFF00_F0F0, 4, 0, 0, 1);
    expect_out(1, "xor");
    issue(SLL, 0, 0, 32'h1, 32'h23, 6, 32'h8, 6, 0, 0, 1);
    expect_out(1, "sll");
    issue(SRL, 0, 0, 32'h8000_0000, 32'd4, 6, 32'h0800_0000, 6, 0, 0, 1);
    expect_out(1, "srl");
    issue(SRA, 0, 0, 32'h8000_0000, 32'd4, 6, 32'hF800_0000, 6, 0, 0, 1);
    expect_out(1, "sra");
    issue(SLT, 0, 0, 32'hFFFF_FFFE, 32'h1, 7, 32'h1, 7, 0, 0, 1);
    expect_out(1, "slt");
    issue(SLTU, 0, 0, 32'hFFFF_FFFE, 32'h1, 7, 32'h0, 7, 0, 0, 1);
    expect_out(1, "sltu");
    step();
    check("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Branches and JALR
    issue(BLT, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'h1, 7, 0, 0, 1, 32'h38, 0);
    expect_out(1, "blt");
    step();
    check("blt pulse once", {31'd0, redirect_valid}, 32'd0);
    issue(BLTU, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'h1, 7, 0, 0, 0, 0, 0);
    expect_out(1, "bltu");
    issue(BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 3, 0, 0, 1, 32'h120, 0);
    expect_out(1, "beq");
    issue(BNE, 32'h100, 32'h20, 32'd5, 32'd5, 3, 0, 0, 0, 0, 0);
    expect_out(1, "bne");
    issue(BGE, 32'h100, 32'h20, 32'hFFFF_FFFE, 32'h1, 3, 0, 0, 0, 0, 0);
    expect_out(1, "bge");
    issue(BGEU, 32'h200, 32'h10, 32'hFFFF_FFFE, 32'h1, 3, 0, 0, 1, 32'h210, 0);
    expect_out(1, "bgeu");
    issue(JALR, 32'h50, 32'h2, 32'h1001, 32'h0, 2, 32'h51, 2, 1, 32'h1003, 1);
    expect_out(1, "jalr");
    step();

    // JAL held by downstream backpressure
    out_ready = 1'b0;
    issue(JAL, 32'h10, 32'h4, 0, 0, 1, 32'h11, 1, 1, 32'h14, 1);
    expect_out(1, "jal");
    for (int i = 0; i < 3; i++) begin
      step();
      check("jal hold out_valid", {31'd0, out_valid}, 32'd1);
      check("jal hold no repulse", {31'd0, redirect_valid}, 32'd0);
      check("jal hold in_ready", {31'd0, in_ready}, 32'd0);
      check("jal hold result", out_result, 32'h11);
    end
    out_ready = 1'b1;
    step();
    check("jal released", {31'd0, out_valid}, 32'd0);

    // Iterative multiply/divide
    issue(DIVU, 0, 0, 32'd100, 32'd7, 9, 32'd14, 9, 0, 0, 1);
    check("divu busy in_ready", {31'd0, in_ready}, 32'd0);
    expect_out(33, "divu");
    issue(REMU, 0, 0, 32'd100, 32'd7, 10, 32'd2, 10, 0, 0, 1);
    check("remu busy in_ready", {31'd0, in_ready}, 32'd0);
    expect_out(33, "remu");
    issue(DIVU, 0, 0, 32'd1234, 32'd0, 11, 32'hFFFF_FFFF, 11, 0, 0, 1);
    expect_out(33, "divu by zero");
    issue(REMU, 0, 0, 32'd1234, 32'd0, 12, 32'd1234, 12, 0, 0, 1);
    expect_out(33, "remu by zero");
    issue(MUL, 0, 0, 32'h0001_0001, 32'h0001_0001, 13, 32'h0002_0001, 13, 0, 0, 1);
    expect_out(33, "mul");
    issue(MUL, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14, 32'h1, 14, 0, 0, 1);
    expect_out(33, "mul wrap");
    step();

    // Flush in the 10th busy cycle of a MUL, with an instruction offered
    issue(MUL, 0, 0, 32'd3, 32'd5, 15, 32'd15, 15, 0, 0, 1);
    repeat (9) step();
    flush = 1'b1; in_valid = 1'b1; in_op = ADD; in_rs1 = 32'd1; in_rs2 = 32'd1; in_rd = 5'd4;
    step();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("flush busy out_valid", {31'd0, out_valid}, 32'd0);
    check("flush busy in_ready", {31'd0, in_ready}, 32'd1);
    watch_quiet(40, "flush busy quiet");
    issue(ADD, 0, 0, 32'd2, 32'd3, 6, 32'd5, 6, 0, 0, 1);
    expect_out(1, "add after flush");
    step();

    // Flush while idle rejects the offered instruction
    flush = 1'b1; in_valid = 1'b1; in_op = ADD; in_rs1 = 32'd9; in_rs2 = 32'd9; in_rd = 5'd9;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush idle reject", {31'd0, out_valid}, 32'd0);

    // Flush drops a held result
    out_ready = 1'b0;
    issue(ADD, 0, 0, 32'd1, 32'd1, 8, 32'd2, 8, 0, 0, 1);
    expect_out(1, "add held");
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush held out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step();

    // Asynchronous reset while busy
    issue(DIVU, 0, 0, 32'd100, 32'd7, 9, 32'd14, 9, 0, 0, 1);
    repeat (5) step();
    rst = 1'b1;
    #1;
    sb.delete();
    check("rst busy out_valid", {31'd0, out_valid}, 32'd0);
    check("rst busy in_ready", {31'd0, in_ready}, 32'd1);
    #3;
    rst = 1'b0;
    watch_quiet(40, "rst busy quiet");

    // Asynchronous reset while a jump result is held
    out_ready = 1'b0;
    issue(JAL, 32'h10, 32'h4, 0, 0, 1, 32'h11, 1, 1, 32'h14, 1);
    expect_out(1, "jal before rst");
    rst = 1'b1;
    #1;
    sb.delete();
    check("rst held out_valid", {31'd0, out_valid}, 32'd0);
    check("rst held out_result", out_result, 32'd0);
    check("rst held out_rd", {27'd0, out_rd}, 32'd0);
    check("rst held redirect_pc", redirect_pc, 32'd0);
    check("rst held redirect_valid", {31'd0, redirect_valid}, 32'd0);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    watch_quiet(5, "rst held quiet");
    issue(ADD, 0, 0, 32'd40, 32'd2, 3, 32'd42, 3, 0, 0, 1);
    expect_out(1, "add after rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
